// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 encodings,
// FSM state type and store lane-formatting helpers.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // Undefined encodings 011/110/111 have funct3[1] set and fall into word size.
    function automatic logic is_word(input logic [2:0] funct3);
        return funct3[1];
    endfunction

    function automatic logic is_half(input logic [2:0] funct3);
        return (funct3[1:0] == 2'b01);
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] funct3,
                                              input logic [1:0] offset);
        logic [3:0] strb;
        if (is_word(funct3))
            strb = 4'hF;
        else if (is_half(funct3))
            strb = offset[1] ? 4'b1100 : 4'b0011;
        else
            strb = 4'b0001 << offset;
        return strb;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0]  funct3,
                                               input logic [31:0] wd);
        logic [31:0] data;
        if (is_word(funct3))
            data = wd;
        else if (is_half(funct3))
            data = {2{wd[15:0]}};
        else
            data = {4{wd[7:0]}};
        return data;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: picks the addressed byte/halfword out of the
// returned word and sign- or zero-extends it according to funct3.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            LB:      result = {{24{byte_sel[7]}}, byte_sel};
            LBU:     result = {24'b0, byte_sel};
            LH:      result = {{16{half_sel[15]}}, half_sel};
            LHU:     result = {16'b0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues one data-memory access per MEM-stage
// load/store, stalls upstream until it completes. Optional MISALIGN_TRAP_EN.
//
// state | meaning
// IDLE  | no access in flight; a new load/store issues its request here
// REQ   | request presented but not yet accepted; EX/MEM held by stallM
// WAIT  | request accepted, waiting for read data / write ack
// DONE  | access complete; pipeline advances, readdataM valid for MEM/WB
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            memreadM,
    input  logic            memwriteM,
    input  logic [2:0]      funct3M,
    input  logic [XLEN-1:0] aluresultM,
    input  logic [XLEN-1:0] writedataM,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_wstrb,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] readdataM,
    output logic            stallM,
    output logic            misalignM
);

    lsu_state_t  state;
    lsu_state_t  state_nxt;
    logic        access;
    logic        misaligned;
    logic [1:0]  offset;
    logic [31:0] load_word;

    assign access = memreadM | memwriteM;
    assign offset = aluresultM[1:0];

`ifdef MISALIGN_TRAP_EN
    logic mis_q;

    assign misaligned = access & ((is_half(funct3M) & offset[0]) |
                                  (is_word(funct3M) & (|offset)));

    // Only an IDLE->DONE trap sets this, so it is high for exactly that DONE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            mis_q <= 1'b0;
        else
            mis_q <= (state == IDLE) & misaligned;
    end

    assign misalignM = mis_q;
`else
    assign misaligned = 1'b0;
    assign misalignM  = 1'b0;
`endif

    load_align u_load_align (
        .rdata  (dmem_rdata),
        .offset (offset),
        .funct3 (funct3M),
        .result (load_word)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (access) begin
                    if (misaligned)
                        state_nxt = DONE;
                    else if (dmem_req_ready)
                        state_nxt = WAIT;
                    else
                        state_nxt = REQ;
                end
            end
            REQ:     if (dmem_req_ready) state_nxt = WAIT;
            WAIT:    if (dmem_rsp_valid) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            readdataM <= '0;
        end else begin
            state <= state_nxt;
            if ((state == WAIT) && dmem_rsp_valid && memreadM)
                readdataM <= load_word;
        end
    end

    // Gated with reset so the handshake and stall drop the moment reset asserts.
    assign dmem_req_valid = reset & (((state == IDLE) & access & ~misaligned) |
                                     (state == REQ));
    assign stallM         = reset & (((state == IDLE) & access) |
                                     (state == REQ) | (state == WAIT));
    assign dmem_we        = reset & memwriteM;
    assign dmem_wstrb     = (reset & memwriteM) ? store_strb(funct3M, offset) : 4'b0000;
    assign dmem_addr      = {aluresultM[XLEN-1:2], 2'b00};
    assign dmem_wdata     = store_data(funct3M, writedataM);

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed cases plus randomized
// accesses against a byte-level reference model.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        memreadM, memwriteM;
    logic [2:0]  funct3M;
    logic [31:0] aluresultM, writedataM;
    logic        dmem_req_valid, dmem_req_ready, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, readdataM;
    logic [3:0]  dmem_wstrb;
    logic        dmem_rsp_valid, stallM, misalignM;

    int n_cmp = 0;
    int n_mis = 0;
    logic [31:0] exp_rd = 32'h0;

    mem_stage_lsu #(.XLEN(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .memreadM       (memreadM),
        .memwriteM      (memwriteM),
        .funct3M        (funct3M),
        .aluresultM     (aluresultM),
        .writedataM     (writedataM),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_wdata     (dmem_wdata),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata),
        .readdataM      (readdataM),
        .stallM         (stallM),
        .misalignM      (misalignM)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_nbytes(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] b,
                                               input logic [31:0] rd);
        logic [31:0] v;
        int n = model_nbytes(f3);
        if (n == 1) begin
            v = (rd >> (8 * b)) & 32'hFF;
            if (f3 == 3'b000 && v >= 32'd128) v = v + 32'hFFFFFF00;
        end else if (n == 2) begin
            v = (rd >> (16 * (b / 2))) & 32'hFFFF;
            if (f3 == 3'b001 && v >= 32'd32768) v = v + 32'hFFFF0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [1:0] b);
        logic [3:0] s = 4'b0;
        int n = model_nbytes(f3);
        int start = (n == 4) ? 0 : (int'(b) - (int'(b) % n));
        for (int i = 0; i < n; i++) s[start + i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] w;
        int n = model_nbytes(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic bit model_mis(input logic [2:0] f3, input logic [1:0] b);
`ifdef MISALIGN_TRAP_EN
        int n = model_nbytes(f3);
        return (n == 2 && b % 2 != 0) || (n == 4 && b != 0);
`else
        return (f3 == 3'b111) && (b == 2'd0) && 1'b0;
`endif
    endfunction

    // Called at posedge+1 with the unit in IDLE; returns at posedge+1 back in IDLE.
    task automatic run_access(input bit is_load, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rdata,
                              input int ready_dly, input int rsp_dly, input bit junk);
        logic [1:0] b = addr[1:0];
        bit mis = model_mis(f3, b);
        memreadM       = is_load;
        memwriteM      = !is_load;
        funct3M        = f3;
        aluresultM     = addr;
        writedataM     = wd;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = ~rdata;
        if (mis) begin
            @(negedge clk);
            check("mis_idle_stall", stallM, 1);
            check("mis_idle_valid", dmem_req_valid, 0);
            @(posedge clk) #1;
            @(negedge clk);
            check("mis_done_stall", stallM, 0);
            check("mis_done_flag", misalignM, 1);
            check("mis_done_valid", dmem_req_valid, 0);
            check("mis_done_rd", readdataM, exp_rd);
        end else begin
            for (int k = 0; k <= ready_dly; k++) begin
                dmem_req_ready = (k == ready_dly);
                dmem_rsp_valid = junk && (k == ready_dly);
                @(negedge clk);
                check("req_valid", dmem_req_valid, 1);
                check("req_stall", stallM, 1);
                check("req_addr", dmem_addr, {addr[31:2], 2'b00});
                check("req_we", dmem_we, !is_load);
                check("req_wstrb", dmem_wstrb, is_load ? 4'b0 : model_strb(f3, b));
                if (!is_load) check("req_wdata", dmem_wdata, model_wdata(f3, wd));
                check("req_misalign", misalignM, 0);
                @(posedge clk) #1;
            end
            dmem_req_ready = 1'b0;
            for (int j = 1; j <= rsp_dly; j++) begin
                dmem_rsp_valid = (j == rsp_dly);
                dmem_rdata     = (j == rsp_dly) ? rdata : ~rdata;
                @(negedge clk);
                check("wait_valid", dmem_req_valid, 0);
                check("wait_stall", stallM, 1);
                @(posedge clk) #1;
            end
            dmem_rsp_valid = 1'b0;
            dmem_rdata     = ~rdata;
            if (is_load) exp_rd = model_load(f3, b, rdata);
            @(negedge clk);
            check("done_stall", stallM, 0);
            check("done_valid", dmem_req_valid, 0);
            check("done_rd", readdataM, exp_rd);
            check("done_misalign", misalignM, 0);
        end
        @(posedge clk) #1;
        memreadM  = 1'b0;
        memwriteM = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input bit noisy);
        for (int i = 0; i < n; i++) begin
            dmem_rsp_valid = noisy ? 1'($urandom_range(1)) : 1'b0;
            dmem_rdata     = $urandom;
            @(negedge clk);
            check("idle_stall", stallM, 0);
            check("idle_valid", dmem_req_valid, 0);
            check("idle_wstrb", dmem_wstrb, 0);
            check("idle_rd", readdataM, exp_rd);
            @(posedge clk) #1;
        end
        dmem_rsp_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        memreadM       = 1'b0;
        memwriteM      = 1'b1;
        funct3M        = 3'b010;
        aluresultM     = 32'h40;
        writedataM     = 32'h1234_5678;
        dmem_req_ready = 1'b1;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", stallM, 0);
        check("rst_valid", dmem_req_valid, 0);
        check("rst_we", dmem_we, 0);
        check("rst_wstrb", dmem_wstrb, 0);
        check("rst_rd", readdataM, 0);
        check("rst_misalign", misalignM, 0);
        memwriteM      = 1'b0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        @(posedge clk) #1;
        reset = 1'b1;
        idle_cycles(2, 1'b1);

        run_access(1, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 0);
        check("lw_const", readdataM, 32'hDEADBEEF);
        run_access(1, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 1, 0);
        check("lb_const", readdataM, 32'hFFFFFF80);
        run_access(1, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 1, 2, 1);
        check("lbu_const", readdataM, 32'h00000080);
        run_access(1, 3'b101, 32'h102, 32'h0, 32'h80FF1234, 0, 1, 0);
        check("lhu_const", readdataM, 32'h000080FF);
        run_access(0, 3'b000, 32'h201, 32'h000000AB, 32'h0, 0, 1, 0);
        check("sb_keeps_rd", readdataM, 32'h000080FF);
        run_access(1, 3'b010, 32'h104, 32'h0, 32'h0BAD_F00D, 3, 1, 0);

        // Reset during WAIT, then a stale response after release.
        memreadM       = 1'b1;
        funct3M        = 3'b010;
        aluresultM     = 32'h300;
        dmem_req_ready = 1'b1;
        @(posedge clk) #1;
        dmem_req_ready = 1'b0;
        @(negedge clk);
        check("wait_pre_rst_stall", stallM, 1);
        #1 reset = 1'b0;
        #1;
        check("rst_wait_stall", stallM, 0);
        check("rst_wait_valid", dmem_req_valid, 0);
        check("rst_wait_rd", readdataM, 0);
        exp_rd   = 32'h0;
        memreadM = 1'b0;
        @(posedge clk) #1;
        reset          = 1'b1;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'hCAFE_BABE;
        @(negedge clk);
        check("stale_rsp_stall", stallM, 0);
        @(posedge clk) #1;
        dmem_rsp_valid = 1'b0;
        idle_cycles(1, 1'b0);

        run_access(1, 3'b010, 32'h102, 32'h0, 32'h1357_9BDF, 0, 1, 0);
        run_access(0, 3'b001, 32'h205, 32'h0000_BEEF, 32'h0, 0, 1, 0);

        for (int t = 0; t < 200; t++) begin
            bit         ld = 1'($urandom_range(1));
            logic [2:0] f3;
            if (ld) f3 = 3'($urandom_range(7));
            else begin
                f3 = 3'($urandom_range(5));
                if (f3 == 3'b100) f3 = 3'b110;
                if (f3 == 3'b101) f3 = 3'b111;
            end
            run_access(ld, f3, $urandom, $urandom, $urandom,
                       $urandom_range(3), $urandom_range(3, 1), 1'($urandom_range(1)));
            idle_cycles($urandom_range(2), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
